// File: rtl/adder_pkg.sv
// Shared sizing helpers for the segmented pipelined adder.
// Segment count is a ceiling divide; the top segment takes whatever bits remain.
package adder_pkg;

  function automatic int num_segs(input int data_width, input int seg_width);
    return (data_width + seg_width - 1) / seg_width;
  endfunction

  function automatic int last_seg_width(input int data_width, input int seg_width);
    return data_width - (num_segs(data_width, seg_width) - 1) * seg_width;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational W-bit ripple add with carry in/out.
// Also reports the carry into its MSB so the top segment can derive signed overflow.
module adder_segment #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         c_msb
);

  logic [W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
  assign sum   = total[W-1:0];
  assign c_out = total[W];
  // sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out by XOR
  assign c_msb = total[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/adder_unit.sv
// Fully pipelined adder: one ripple segment per stage, operands skewed in,
// partial sums deskewed out so a whole result appears on one cycle.
module adder_unit
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SEG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  c_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  c_out,
  output logic                  ovf
);

  localparam int NUM_SEGS = num_segs(DATA_WIDTH, SEG_WIDTH);
  localparam int LAST_W   = last_seg_width(DATA_WIDTH, SEG_WIDTH);

  logic [NUM_SEGS-1:0]   valid_reg;
  logic [NUM_SEGS:0]     carry_chain;
  logic [NUM_SEGS-1:0]   msb_carry;
  logic [DATA_WIDTH-1:0] sum_next;
  logic                  ovf_next;
  logic                  out_en;
  logic [DATA_WIDTH-1:0] sum_reg;
  logic                  c_out_reg;
  logic                  ovf_reg;

  assign carry_chain[0] = c_in;

  for (genvar gi = 0; gi < NUM_SEGS; gi++) begin : g_seg
    localparam int W  = (gi == NUM_SEGS - 1) ? LAST_W : SEG_WIDTH;
    localparam int LO = gi * SEG_WIDTH;

    logic [W-1:0] seg_a;
    logic [W-1:0] seg_b;
    logic [W-1:0] seg_sum;
    logic         seg_cout;

    if (gi == 0) begin : g_direct
      assign seg_a = a[LO +: W];
      assign seg_b = b[LO +: W];
    end else begin : g_skew
      // Operand slice waits gi cycles for the carry from the segment below
      logic [W-1:0] a_skew [gi];
      logic [W-1:0] b_skew [gi];

      always_ff @(posedge clk) begin
        a_skew[0] <= a[LO +: W];
        b_skew[0] <= b[LO +: W];
        for (int j = 1; j < gi; j++) begin
          a_skew[j] <= a_skew[j-1];
          b_skew[j] <= b_skew[j-1];
        end
      end

      assign seg_a = a_skew[gi-1];
      assign seg_b = b_skew[gi-1];
    end

    adder_segment #(.W(W)) u_seg (
      .a     (seg_a),
      .b     (seg_b),
      .c_in  (carry_chain[gi]),
      .sum   (seg_sum),
      .c_out (seg_cout),
      .c_msb (msb_carry[gi])
    );

    if (gi == NUM_SEGS - 1) begin : g_last
      assign sum_next[LO +: W]   = seg_sum;
      assign carry_chain[gi + 1] = seg_cout;
    end else begin : g_mid
      logic         carry_reg;
      logic [W-1:0] deskew [NUM_SEGS-1-gi];

      always_ff @(posedge clk) begin
        carry_reg <= seg_cout;
        deskew[0] <= seg_sum;
        for (int j = 1; j < NUM_SEGS - 1 - gi; j++) begin
          deskew[j] <= deskew[j-1];
        end
      end

      assign carry_chain[gi + 1] = carry_reg;
      assign sum_next[LO +: W]   = deskew[NUM_SEGS-2-gi];
    end
  end

  assign ovf_next = msb_carry[NUM_SEGS-1] ^ carry_chain[NUM_SEGS];

  // Result registers load only when the operation reaching the last segment is valid
  if (NUM_SEGS == 1) begin : g_en_single
    assign out_en = in_valid;
  end else begin : g_en_multi
    assign out_en = valid_reg[NUM_SEGS-2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      valid_reg[0] <= in_valid;
      for (int i = 1; i < NUM_SEGS; i++) begin
        valid_reg[i] <= valid_reg[i-1];
      end
      if (out_en) begin
        sum_reg   <= sum_next;
        c_out_reg <= carry_chain[NUM_SEGS];
        ovf_reg   <= ovf_next;
      end
    end
  end

  assign out_valid = valid_reg[NUM_SEGS-1];
  assign sum       = sum_reg;
  assign c_out     = c_out_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_adder_unit.sv
// Directed bench for adder_unit: default 16/8 instance plus a 13/4 instance
// fed random operands and compared against a reference add queued per issue.
module tb_adder_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        out_valid;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;

  logic        in_valid13;
  logic [12:0] a13;
  logic [12:0] b13;
  logic        c_in13;
  logic        out_valid13;
  logic [12:0] sum13;
  logic        c_out13;
  logic        ovf13;

  adder_unit #(.DATA_WIDTH(16), .SEG_WIDTH(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  adder_unit #(.DATA_WIDTH(13), .SEG_WIDTH(4)) u_dut13 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid13),
    .a         (a13),
    .b         (b13),
    .c_in      (c_in13),
    .out_valid (out_valid13),
    .sum       (sum13),
    .c_out     (c_out13),
    .ovf       (ovf13)
  );

  typedef struct {
    logic [14:0] res;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   tick     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tick++;
  endtask

  task automatic drive(input logic v, input logic [15:0] ia, input logic [15:0] ib, input logic ic);
    in_valid = v;
    a        = ia;
    b        = ib;
    c_in     = ic;
  endtask

  // Invalid cycles carry junk operands, which must not leak into the outputs
  task automatic idle();
    drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  task automatic check_out(input string tag, input logic v, input logic [15:0] s,
                           input logic co, input logic ov);
    check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, "_res"}, {14'd0, ovf, c_out, sum}, {14'd0, ov, co, s});
  endtask

  task automatic run_one(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                         input logic ic, input logic [15:0] s, input logic co, input logic ov);
    drive(1'b1, ia, ib, ic);
    step();
    idle();
    check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    step();
    check_out(tag, 1'b1, s, co, ov);
  endtask

  task automatic step13();
    step();
    if (out_valid13) begin
      if (q.size() == 0) begin
        check("sw_extra_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sw_latency", tick, e.due);
        check("sw_res", {17'd0, ovf13, c_out13, sum13}, {17'd0, e.res});
      end
    end
  endtask

  task automatic issue13(input logic [12:0] ia, input logic [12:0] ib, input logic ic);
    logic [13:0] tot;
    logic        ov;
    exp_t        e;
    tot        = {1'b0, ia} + {1'b0, ib} + {13'd0, ic};
    ov         = (ia[12] == ib[12]) && (tot[12] != ia[12]);
    in_valid13 = 1'b1;
    a13        = ia;
    b13        = ib;
    c_in13     = ic;
    e.res      = {ov, tot};
    e.due      = tick + 1 + 3;
    q.push_back(e);
    step13();
  endtask

  initial begin
    rst        = 1'b1;
    in_valid13 = 1'b0;
    a13        = '0;
    b13        = '0;
    c_in13     = 1'b0;
    // Reset wins over a valid input on the same edge
    drive(1'b1, 16'd5, 16'd5, 1'b0);
    step();
    step();
    check_out("reset", 1'b0, 16'd0, 1'b0, 1'b0);
    check("reset13", {17'd0, out_valid13, ovf13, c_out13, sum13}, 32'd0);

    rst = 1'b0;
    drive(1'b1, 16'd1, 16'd1, 1'b1);
    step();
    drive(1'b1, 16'd10, 16'd10, 1'b0);
    step();
    check_out("add1", 1'b1, 16'd3, 1'b0, 1'b0);
    drive(1'b1, 16'd50, 16'd60, 1'b1);
    step();
    check_out("add2", 1'b1, 16'd20, 1'b0, 1'b0);
    idle();
    step();
    check_out("add3", 1'b1, 16'd111, 1'b0, 1'b0);
    idle();
    step();
    check_out("drain_hold", 1'b0, 16'd111, 1'b0, 1'b0);

    run_one("carry8", 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);
    run_one("wrap",   16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_one("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_one("neg_ok", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_one("mixed",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

    drive(1'b1, 16'h0100, 16'h0200, 1'b0);
    step();
    idle();
    step();
    check_out("bub_a", 1'b1, 16'h0300, 1'b0, 1'b0);
    drive(1'b1, 16'h1000, 16'h0001, 1'b1);
    step();
    check_out("bub_gap", 1'b0, 16'h0300, 1'b0, 1'b0);
    idle();
    step();
    check_out("bub_b", 1'b1, 16'h1002, 1'b0, 1'b0);

    drive(1'b1, 16'h1111, 16'h1111, 1'b0);
    step();
    drive(1'b1, 16'h2222, 16'h2222, 1'b0);
    rst = 1'b1;
    step();
    check_out("rst_flush", 1'b0, 16'd0, 1'b0, 1'b0);
    rst = 1'b0;
    idle();
    step();
    check_out("rst_post1", 1'b0, 16'd0, 1'b0, 1'b0);
    step();
    check_out("rst_post2", 1'b0, 16'd0, 1'b0, 1'b0);
    run_one("after_rst", 16'd3, 16'd4, 1'b0, 16'd7, 1'b0, 1'b0);

    in_valid = 1'b0;
    issue13(13'h1FFF, 13'h0000, 1'b1);
    issue13(13'h0FFF, 13'h0001, 1'b0);
    issue13(13'h1000, 13'h1000, 1'b0);
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        in_valid13 = 1'b0;
        a13        = 13'($urandom);
        b13        = 13'($urandom);
        step13();
      end else begin
        issue13(13'($urandom), 13'($urandom), 1'($urandom));
      end
    end
    in_valid13 = 1'b0;
    for (int i = 0; i < 12 && q.size() != 0; i++) begin
      step13();
    end
    check("sw_drain", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
